prga_decrypt_fsm: RTL

PRGA_DECRYPT_FSM -- requirements
Module: prga_decrypt_fsm

---
 rtl/rc4_pkg.sv | 29 ++
 rtl/rc4_char_check.sv | 11 +
 rtl/prga_decrypt_fsm.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 decrypt definitions: FSM state encoding, default message length,
// and the bounds of the legal plaintext alphabet (space and lowercase letters).
package rc4_pkg;

   localparam int MSG_LEN_DEF = 32;

   localparam logic [7:0] SPACE   = 8'd32;
   localparam logic [7:0] LOWER_A = 8'd97;
   localparam logic [7:0] LOWER_Z = 8'd122;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      INC_I     = 4'd1,
      WAIT_SI   = 4'd2,
      READ_SI   = 4'd3,
      SET_J     = 4'd4,
      WAIT_SJ   = 4'd5,
      READ_SJ   = 4'd6,
      WRITE_I   = 4'd7,
      WRITE_J   = 4'd8,
      SET_F     = 4'd9,
      WAIT_F    = 4'd10,
      READ_F    = 4'd11,
      WRITE_DEC = 4'd12,
      NEXT      = 4'd13,
      DONE      = 4'd14
   } state_e;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext filter: a byte is legal if it is a space or 'a'..'z'.
module rc4_char_check
   import rc4_pkg::*;
(
   input  logic [7:0] ch_i,
   output logic       legal_o
);

   assign legal_o = (ch_i == SPACE) || ((ch_i >= LOWER_A) && (ch_i <= LOWER_Z));

endmodule

// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA decrypt engine: walks the pre-shuffled S memory, XORs the keystream
// with ciphertext ROM bytes and writes plaintext RAM, optionally aborting on a bad char.
module prga_decrypt_fsm
   import rc4_pkg::*;
#(
   parameter int MSG_LEN    = MSG_LEN_DEF,
   parameter bit CHECK_TEXT = 1'b1
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] s_address,
   output logic [7:0] s_data,
   output logic       s_wren,
   input  logic [7:0] s_q,
   output logic [4:0] rom_address,
   input  logic [7:0] rom_q,
   output logic [4:0] dec_address,
   output logic [7:0] dec_data,
   output logic       dec_wren,
   output logic       done,
   output logic       fail
);

   localparam logic [4:0] K_LAST = 5'(MSG_LEN - 1);

   state_e     state_q, state_d;
   logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d;
   logic [4:0] k_q, k_d;
   logic [7:0] s_addr_q, s_addr_d, s_data_q, s_data_d;
   logic       s_wren_q, s_wren_d;
   logic [4:0] dec_addr_q, dec_addr_d;
   logic [7:0] dec_data_q, dec_data_d;
   logic       dec_wren_q, dec_wren_d;
   logic       done_q, done_d, fail_q, fail_d;
   logic       legal;

   // f ^ rom_q is the byte just written: rom_address is still k during NEXT
   rc4_char_check u_chk (
      .ch_i    (f_q ^ rom_q),
      .legal_o (legal)
   );

   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      si_d       = si_q;
      sj_d       = sj_q;
      f_d        = f_q;
      s_addr_d   = s_addr_q;
      s_data_d   = s_data_q;
      s_wren_d   = 1'b0;
      dec_addr_d = dec_addr_q;
      dec_data_d = dec_data_q;
      dec_wren_d = 1'b0;
      done_d     = done_q;
      fail_d     = fail_q;
      unique case (state_q)
         IDLE: begin
            i_d = 8'd0;
            j_d = 8'd0;
            k_d = 5'd0;
            if (start) state_d = INC_I;
         end
         INC_I: begin
            i_d      = i_q + 8'd1;
            s_addr_d = i_q + 8'd1;
            state_d  = WAIT_SI;
         end
         WAIT_SI: state_d = READ_SI;
         READ_SI: begin
            si_d    = s_q;
            j_d     = j_q + s_q;
            state_d = SET_J;
         end
         SET_J: begin
            s_addr_d = j_q;
            state_d  = WAIT_SJ;
         end
         WAIT_SJ: state_d = READ_SJ;
         // write strobes are registered one state early so they are high exactly in WRITE_I/WRITE_J
         READ_SJ: begin
            sj_d     = s_q;
            s_addr_d = i_q;
            s_data_d = s_q;
            s_wren_d = 1'b1;
            state_d  = WRITE_I;
         end
         WRITE_I: begin
            s_addr_d = j_q;
            s_data_d = si_q;
            s_wren_d = 1'b1;
            state_d  = WRITE_J;
         end
         WRITE_J: state_d = SET_F;
         SET_F: begin
            s_addr_d = si_q + sj_q;
            state_d  = WAIT_F;
         end
         WAIT_F: state_d = READ_F;
         READ_F: begin
            f_d        = s_q;
            dec_addr_d = k_q;
            dec_data_d = s_q ^ rom_q;
            dec_wren_d = 1'b1;
            state_d    = WRITE_DEC;
         end
         WRITE_DEC: state_d = NEXT;
         NEXT: begin
            if (CHECK_TEXT && !legal) begin
               done_d  = 1'b1;
               fail_d  = 1'b1;
               state_d = DONE;
            end else if (k_q == K_LAST) begin
               done_d  = 1'b1;
               fail_d  = 1'b0;
               state_d = DONE;
            end else begin
               k_d     = k_q + 5'd1;
               state_d = INC_I;
            end
         end
         DONE: begin
            if (!start) begin
               done_d  = 1'b0;
               fail_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         i_q        <= 8'd0;
         j_q        <= 8'd0;
         k_q        <= 5'd0;
         si_q       <= 8'd0;
         sj_q       <= 8'd0;
         f_q        <= 8'd0;
         s_addr_q   <= 8'd0;
         s_data_q   <= 8'd0;
         s_wren_q   <= 1'b0;
         dec_addr_q <= 5'd0;
         dec_data_q <= 8'd0;
         dec_wren_q <= 1'b0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         si_q       <= si_d;
         sj_q       <= sj_d;
         f_q        <= f_d;
         s_addr_q   <= s_addr_d;
         s_data_q   <= s_data_d;
         s_wren_q   <= s_wren_d;
         dec_addr_q <= dec_addr_d;
         dec_data_q <= dec_data_d;
         dec_wren_q <= dec_wren_d;
         done_q     <= done_d;
         fail_q     <= fail_d;
      end
   end

   assign s_address   = s_addr_q;
   assign s_data      = s_data_q;
   assign s_wren      = s_wren_q;
   assign rom_address = k_q;
   assign dec_address = dec_addr_q;
   assign dec_data    = dec_data_q;
   assign dec_wren    = dec_wren_q;
   assign done        = done_q;
   assign fail        = fail_q;

endmodule
